// File: rtl/imem_fetch_unit_if.sv
// Bus bundle for imem_fetch_unit: instruction-memory req/ack side, core valid/ready side,
// redirect input and queue occupancy. master = fetch unit view, slave = memory/core view.
interface imem_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CNT_W   = 3
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [CNT_W-1:0]   q_count;

  modport master (
    output mem_req, mem_addr, instr_valid, instr_out, instr_pc, q_count,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_out, instr_pc, q_count,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// MiniMIPS instruction fetch: single-outstanding req/ack fetch into a DEPTH-entry prefetch queue.
// Define FETCH_BYPASS_EN to forward an acked word straight to the core when the queue is empty.
module imem_fetch_unit #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clock,
  input logic               reset,
  imem_fetch_unit_if.master bus
);

  localparam int unsigned      PTR_W = $clog2(DEPTH);
  localparam int unsigned      CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t             state;
  logic               mem_req_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [ADDR_W-1:0]  fetch_pc;

  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0]   count, count_n;

  logic               head_valid;
  logic [INSTR_W-1:0] head_instr, head_instr_n;
  logic [ADDR_W-1:0]  head_pc, head_pc_n;

  logic               take;
  logic               push;
  logic               pop;

  // A fetch completes only for a live request in REQ; acks in DRAIN are discarded.
  assign take = (state == REQ) && mem_req_q && bus.mem_ack && !bus.redirect;
  assign pop  = head_valid && bus.instr_ready && !bus.redirect;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass          = take && (count == '0);
  assign push            = take && !(bypass && bus.instr_ready);
  assign bus.instr_valid = head_valid || bypass;
  assign bus.instr_out   = bypass ? bus.mem_rdata : head_instr;
  assign bus.instr_pc    = bypass ? mem_addr_q : head_pc;
`else
  assign push            = take;
  assign bus.instr_valid = head_valid;
  assign bus.instr_out   = head_instr;
  assign bus.instr_pc    = head_pc;
`endif

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.q_count  = count;

  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    if (bus.redirect) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + 1'b1;
      if (pop)  rd_ptr_n = rd_ptr + 1'b1;
      count_n = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head register is loaded from the entry that will be at the head after this edge;
  // a push landing on that slot (queue empty or draining to empty) is forwarded directly.
  always_comb begin
    head_instr_n = instr_q[rd_ptr_n];
    head_pc_n    = pc_q[rd_ptr_n];
    if (push && (wr_ptr == rd_ptr_n)) begin
      head_instr_n = bus.mem_rdata;
      head_pc_n    = mem_addr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      instr_q[wr_ptr] <= bus.mem_rdata;
      pc_q[wr_ptr]    <= mem_addr_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_instr <= '0;
      head_pc    <= '0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count      <= count_n;
      head_valid <= (count_n != '0);
      head_instr <= head_instr_n;
      head_pc    <= head_pc_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc   <= RESET_PC;
    end else begin
      if (bus.redirect) fetch_pc <= bus.redirect_pc;
      unique case (state)
        IDLE: begin
          if (!bus.redirect && (count < FULL)) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_req_q) begin
            if (bus.mem_ack) begin
              mem_req_q <= 1'b0;
              if (bus.redirect) begin
                state <= IDLE;
              end else begin
                fetch_pc   <= fetch_pc + 1'b1;
                mem_addr_q <= fetch_pc + 1'b1;
                state      <= (count_n < FULL) ? REQ : IDLE;
              end
            end else if (bus.redirect) begin
              state <= DRAIN;
            end
          end else if (bus.redirect) begin
            // Gap cycle between requests: nothing in flight, so no drain is needed.
            state <= IDLE;
          end else if (count < FULL) begin
            mem_req_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomized scoreboard bench for imem_fetch_unit: memory responder + fetch-stream model
// push expected {instr, pc}; an independent monitor pops on every core handshake.
module tb_imem_fetch_unit;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [15:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clock;
  logic reset;

  imem_fetch_unit_if #(.ADDR_W(32), .INSTR_W(16), .CNT_W(3)) bus ();

  imem_fetch_unit #(
    .DEPTH(DEPTH),
    .ADDR_W(32),
    .INSTR_W(16),
    .RESET_PC(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ent_t        sb[$];
  logic [31:0] model_pc;
  bit          stale;
  bit          busy;
  int unsigned delay;
  int unsigned waited;
  bit          push_flag;
  bit          mon_en;
  int          model_cnt;
  int unsigned delivered;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return (a[15:0] + 16'h1000) ^ a[31:16];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(2, 0))
      0:       return $urandom;
      1:       return 32'($urandom_range(255, 0));
      default: return 32'hFFFF_FFFF - 32'($urandom_range(3, 0));
    endcase
  endfunction

  // One bus cycle of memory responder + core driver; the model advances in step with it.
  task automatic step(input int unsigned rdy_pct, input int unsigned ack_lo,
                      input int unsigned ack_hi, input int unsigned redir_pct,
                      input bit force_redir, input logic [31:0] force_pc);
    bit          ack;
    bit          redir;
    logic [31:0] rpc;
    @(posedge clock);
    #1;
    ack = 1'b0;
    if (bus.mem_req) begin
      if (!busy) begin
        busy   = 1'b1;
        delay  = $urandom_range(ack_hi, ack_lo);
        waited = 0;
      end
      if (waited >= delay) begin
        ack  = 1'b1;
        busy = 1'b0;
      end else begin
        waited++;
      end
    end
    redir     = force_redir || ($urandom_range(99, 0) < redir_pct);
    rpc       = force_redir ? force_pc : pick_pc();
    push_flag = 1'b0;
    if (ack) begin
      if (stale) begin
        stale = 1'b0;
      end else if (!redir) begin
        chk("fetch_addr", 64'(bus.mem_addr), 64'(model_pc));
        sb.push_back('{instr: mem_word(model_pc), pc: model_pc});
        model_pc  = model_pc + 32'd1;
        push_flag = 1'b1;
      end
    end
    if (redir) begin
      if (bus.mem_req && !ack) stale = 1'b1;
      sb.delete();
      model_pc = rpc;
    end
    bus.mem_ack     = ack;
    bus.mem_rdata   = ack ? mem_word(bus.mem_addr) : 16'($urandom);
    bus.instr_ready = ($urandom_range(99, 0) < rdy_pct);
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic reset_model();
    sb.delete();
    model_pc        = 32'h0;
    stale           = 1'b0;
    busy            = 1'b0;
    push_flag       = 1'b0;
    model_cnt       = 0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"},     64'(bus.mem_req),     64'd0);
    chk({tag, "_mem_addr"},    64'(bus.mem_addr),    64'd0);
    chk({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'd0);
    chk({tag, "_instr_out"},   64'(bus.instr_out),   64'd0);
    chk({tag, "_instr_pc"},    64'(bus.instr_pc),    64'd0);
    chk({tag, "_q_count"},     64'(bus.q_count),     64'd0);
  endtask

  // Monitor: sampled on the falling edge, between driver updates and the next active edge.
  initial begin
    bit   prev_req;
    bit   prev_ack;
    logic [31:0] prev_addr;
    bit   popped;
    ent_t e;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        chk("q_count", 64'(bus.q_count), 64'(model_cnt));
        chk("instr_valid", 64'(bus.instr_valid), 64'(model_cnt != 0));
        popped = 1'b0;
        if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
          popped = 1'b1;
          delivered++;
          if (sb.size() == 0) begin
            chk("pop_with_empty_scoreboard", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("instr_out", 64'(bus.instr_out), 64'(e.instr));
            chk("instr_pc", 64'(bus.instr_pc), 64'(e.pc));
          end
        end
        if (prev_req && !prev_ack) begin
          chk("req_held", 64'(bus.mem_req), 64'd1);
          chk("addr_held", 64'(bus.mem_addr), 64'(prev_addr));
        end
        if (bus.mem_req && !prev_req)
          chk("issue_has_space", 64'(model_cnt < int'(DEPTH)), 64'd1);
        if (bus.redirect) model_cnt = 0;
        else model_cnt = model_cnt + int'(push_flag) - int'(popped);
        prev_req  = bus.mem_req;
        prev_ack  = bus.mem_ack;
        prev_addr = bus.mem_addr;
      end
    end
  end

  initial begin
    int unsigned d0;
    int unsigned n;
    mon_en    = 1'b0;
    delivered = 0;
    reset     = 1'b1;
    reset_model();
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Back-to-back zero-wait fetch with the core always ready.
    repeat (12) step(100, 0, 0, 0, 1'b0, '0);

    // Restart at 0, then redirect to 0x40 while the fetch of address 2 is pending.
    step(100, 4, 4, 0, 1'b1, 32'h0);
    n = 0;
    while (!(bus.mem_req && model_pc == 32'd2) && n < 60) begin
      step(100, 4, 4, 0, 1'b0, '0);
      n++;
    end
    chk("reached_addr2", 64'(model_pc), 64'd2);
    step(100, 4, 4, 0, 1'b1, 32'h40);
    repeat (20) step(100, 0, 2, 0, 1'b0, '0);

    // Core stalled: queue fills to DEPTH and fetching stops; one pop reopens one slot.
    repeat (20) step(0, 0, 0, 0, 1'b0, '0);
    chk("fill_q_count", 64'(bus.q_count), 64'(DEPTH));
    chk("fill_mem_req", 64'(bus.mem_req), 64'd0);
    step(100, 0, 0, 0, 1'b0, '0);
    repeat (8) step(0, 0, 0, 0, 1'b0, '0);
    chk("refill_q_count", 64'(bus.q_count), 64'(DEPTH));
    chk("refill_mem_req", 64'(bus.mem_req), 64'd0);

    // Slow memory: five wait cycles per request.
    repeat (40) step(100, 5, 5, 0, 1'b0, '0);

    // Address wrap past 0xFFFFFFFF.
    step(100, 0, 0, 0, 1'b1, 32'hFFFF_FFFE);
    repeat (12) step(100, 0, 1, 0, 1'b0, '0);

    // Random mix of stalls, latencies and redirects.
    repeat (1500) step(60, 0, 3, 5, 1'b0, '0);

    // Asynchronous reset while a request is in flight.
    n = 0;
    while (!bus.mem_req && n < 40) begin
      step(100, 6, 6, 0, 1'b0, '0);
      n++;
    end
    chk("mid_req_seen", 64'(bus.mem_req), 64'd1);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    reset_model();
    @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    d0 = delivered;
    repeat (500) step(70, 0, 4, 3, 1'b0, '0);
    chk("progress_after_reset", 64'(delivered > d0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
